// File: rtl/interval_timer_pkg.sv
// Shared types and helpers for the interval timer arbiter: FSM states,
// default width and the round-robin winner pick.
package interval_timer_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int MAX_REQ       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } pick_t;

    // Scans ptr+1, ptr+2, ... mod nreq; iterating the offsets downwards lets
    // the lowest offset with a request win by being assigned last.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [2:0]         ptr,
                                      input int                 nreq);
        pick_t p;
        int    idx;
        p = '0;
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= nreq) begin
                idx = (int'(ptr) + k) % nreq;
                if (req[idx]) begin
                    p.valid = 1'b1;
                    p.idx   = 3'(idx);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/interval_counter.sv
// Shared free-running interval up-counter with synchronous clear and enable;
// clear takes priority over enable.
module interval_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/interval_timer_arbiter.sv
// Round-robin arbiter that lends the shared interval counter to one requester
// at a time, times its interval and pulses done on the terminal count.
module interval_timer_arbiter
    import interval_timer_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   len,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic [WIDTH-1:0]        count
);

    localparam int OW = $clog2(NREQ);

    // Handshake: req is a level held by the client until done, or dropped to
    // abandon; gnt is one-hot and registered, high for RUN plus the DONE cycle,
    // and done is a single-cycle pulse in that last granted cycle.
    state_t            state_q, state_d;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [WIDTH-1:0]  len_q, len_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              cnt_clr;
    logic              cnt_en;
    logic [MAX_REQ-1:0] req_ext;
    pick_t             pick;
    logic [NREQ-1:0]   one_hot_w;
    logic [WIDTH-1:0]  last_count;

    interval_counter #(.WIDTH(WIDTH)) u_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count)
    );

    always_comb begin
        req_ext           = '0;
        req_ext[NREQ-1:0] = req;
    end

    assign pick       = rr_pick(req_ext, 3'(ptr_q), NREQ);
    assign one_hot_w  = {{(NREQ-1){1'b0}}, 1'b1} << pick.idx;
    // len_q of zero wraps to all-ones here, giving a full 2^WIDTH interval.
    assign last_count = len_q - 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        len_d   = len_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (pick.valid) begin
                    state_d = RUN;
                    owner_d = pick.idx[OW-1:0];
                    gnt_d   = one_hot_w;
                    len_d   = len[int'(pick.idx)*WIDTH +: WIDTH];
                end
            end
            RUN: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    ptr_d   = owner_q;
                    owner_d = '0;
                    gnt_d   = '0;
                    cnt_clr = 1'b1;
                end else if (count == last_count) begin
                    state_d = DONE;
                    done_d  = gnt_q;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = owner_q;
                owner_d = '0;
                gnt_d   = '0;
                cnt_clr = 1'b1;
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
                gnt_d   = '0;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= OW'(NREQ - 1);
            owner_q <= '0;
            len_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            len_q   <= len_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign busy  = (state_q != IDLE);
    assign owner = owner_q;

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Bench for interval_timer_arbiter: directed scenarios plus random traffic,
// all checked cycle by cycle against a grant-level reference model.
module tb_interval_timer_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] len;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           busy;
    logic [1:0]     owner;
    logic [W-1:0]   count;

    int n_checks;
    int n_errors;

    // Reference model: who holds the grant, how many cycles into it we are,
    // and its interval length in cycles (1..256).
    int m_owner;
    int m_el;
    int m_len;
    int m_ptr;

    interval_timer_arbiter #(.NREQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len   (len),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .owner (owner),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_el    = 0;
        m_len   = 0;
        m_ptr   = N - 1;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N*W-1:0] l);
        int lv;
        if (m_owner < 0) begin
            for (int k = N; k >= 1; k--) begin
                if (r[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
            end
            if (m_owner >= 0) begin
                lv    = int'(l[m_owner*W +: W]);
                m_len = (lv == 0) ? 256 : lv;
                m_el  = 0;
            end
        end else if (m_el < m_len) begin
            if (!r[m_owner]) begin
                m_ptr   = m_owner;
                m_owner = -1;
            end else begin
                m_el++;
            end
        end else begin
            m_ptr   = m_owner;
            m_owner = -1;
        end
    endtask

    task automatic check_outputs();
        if (m_owner < 0) begin
            chk_eq("gnt_idle", 32'(gnt), 32'd0);
            chk_eq("done_idle", 32'(done), 32'd0);
            chk_eq("busy_idle", 32'(busy), 32'd0);
            chk_eq("owner_idle", 32'(owner), 32'd0);
            chk_eq("count_idle", 32'(count), 32'd0);
        end else begin
            chk_eq("gnt", 32'(gnt), 32'd1 << m_owner);
            chk_eq("busy", 32'(busy), 32'd1);
            chk_eq("owner", 32'(owner), 32'(m_owner));
            if (m_el < m_len) begin
                chk_eq("done_run", 32'(done), 32'd0);
                chk_eq("count", 32'(count), 32'(m_el));
            end else begin
                chk_eq("done", 32'(done), 32'd1 << m_owner);
            end
        end
    endtask

    task automatic run_cycle(input logic [N-1:0] r, input logic [N*W-1:0] l);
        @(negedge clk);
        check_outputs();
        req = r;
        len = l;
        model_step(r, l);
    endtask

    function automatic logic [N*W-1:0] pack_len(input int l0, input int l1, input int l2, input int l3);
        return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    initial begin
        logic [N-1:0]   r;
        logic [N*W-1:0] l;
        bit             aborted;
        int             guard;
        int             done_seen;

        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        req      = '0;
        len      = '0;
        model_reset();
        @(negedge clk);
        check_outputs();
        reset = 1'b0;

        // Single request, len 5: six granted cycles then idle.
        l = pack_len(5, 0, 0, 0);
        repeat (7) run_cycle(4'b0001, l);
        repeat (3) run_cycle(4'b0000, l);

        // All four requesting with len 2: rotation 0,1,2,3,0.
        l = pack_len(2, 2, 2, 2);
        repeat (20) run_cycle(4'b1111, l);
        repeat (2) run_cycle(4'b0000, l);

        // Length 0 wraps to 256 counting cycles.
        l = pack_len(0, 0, 0, 0);
        done_seen = 0;
        repeat (258) begin
            run_cycle(4'b0100, l);
            if (done[2]) done_seen++;
        end
        repeat (2) run_cycle(4'b0000, l);
        chk_eq("wrap_done_pulses", 32'(done_seen), 32'd1);

        // Length 1: two-cycle grant.
        l = pack_len(0, 1, 0, 0);
        repeat (3) run_cycle(4'b0010, l);
        repeat (2) run_cycle(4'b0000, l);

        // Abort: requester 1 drops at count 3 while requester 2 waits.
        l = pack_len(0, 10, 3, 0);
        run_cycle(4'b0010, l);
        aborted = 1'b0;
        repeat (14) begin
            if (!aborted && m_owner == 1 && m_el == 3) begin
                r       = 4'b0100;
                aborted = 1'b1;
            end else begin
                r = aborted ? 4'b0100 : 4'b0110;
            end
            run_cycle(r, l);
        end
        chk_eq("abort_reached", 32'(aborted), 32'd1);
        repeat (6) run_cycle(4'b0000, l);

        // Asynchronous reset at count 4 of a running grant.
        l = pack_len(8, 0, 0, 0);
        guard = 0;
        while (!(m_owner == 0 && m_el == 4) && guard < 20) begin
            run_cycle(4'b0001, l);
            guard++;
        end
        chk_eq("reset_setup_timeout", 32'(guard < 20), 32'd1);
        @(negedge clk);
        check_outputs();
        reset = 1'b1;
        #1;
        chk_eq("rst_gnt", 32'(gnt), 32'd0);
        chk_eq("rst_done", 32'(done), 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_owner", 32'(owner), 32'd0);
        chk_eq("rst_count", 32'(count), 32'd0);
        model_reset();
        @(negedge clk);
        check_outputs();
        reset = 1'b0;
        l     = pack_len(0, 3, 0, 3);
        req   = 4'b1010;
        len   = l;
        model_step(req, l);
        chk_eq("post_reset_winner", 32'(m_owner), 32'd1);
        repeat (10) run_cycle(4'b1010, l);
        repeat (6) run_cycle(4'b0000, l);

        // len changes mid-interval are ignored.
        repeat (10) begin
            l = (m_owner == 0 && m_el >= 2) ? pack_len(9, 0, 0, 0) : pack_len(5, 0, 0, 0);
            run_cycle(4'b0001, l);
        end
        repeat (3) run_cycle(4'b0000, l);

        // Random traffic: slowly changing request levels, random lengths.
        r = '0;
        l = pack_len(3, 3, 3, 3);
        repeat (600) begin
            if ($urandom_range(0, 5) == 0) r[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 3) == 0) l[$urandom_range(0, N - 1)*W +: W] = 8'($urandom_range(1, 12));
            run_cycle(r, l);
        end
        repeat (3) run_cycle(4'b0000, l);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/interval_timer_arbiter.md
# interval_timer_arbiter

Shares one 8-bit interval counter among several requesters, each of which wants to time an interval of its own length. The block arbitrates round-robin and grants the counter to one requester. It loads and runs the counter, detects the terminal count, and reports completion with a one-cycle done pulse. It sits between the client blocks and the shared `interval_counter` instance, which is the only up-counter in the timing subsystem.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `WIDTH`, default 8: counter and interval-length width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req`  in  NREQ  per-requester request level; held until `done` or until the requester abandons the request.
- `len`  in  NREQ*WIDTH  per-requester interval length; slice i = `len[i*WIDTH +: WIDTH]`; sampled only at grant.
- `gnt`  out  NREQ  one-hot grant; all-zero when idle.
- `done`  out  NREQ  one-hot, one-cycle completion pulse.
- `busy`  out  1  high whenever state != IDLE.
- `owner`  out  $clog2(NREQ)  index of the current grantee; 0 when idle.
- `count`  out  WIDTH  live counter value, for observation.

## Operation
- FSM has three states: IDLE, RUN and DONE.
- **IDLE:**
  - If `req` != 0, pick winner w as the first asserted bit scanning ptr+1, ptr+2, … mod NREQ.
  - Next edge: state=RUN, `gnt[w]`=1, `owner`=w, `len_q`=`len[w]`, counter cleared to 0.
- **RUN:**
  - Counter increments by 1 every cycle, mod 2^WIDTH.
  - When `count == len_q - 1` (mod 2^WIDTH), next edge goes to DONE.
- **DONE:**
  - `gnt[w]` stays high and `done[w]`=1 for exactly this cycle.
  - Next edge: `ptr`=w, `gnt`=0, state=IDLE, counter cleared.
- **Interval length:** RUN lasts exactly `len_q` cycles. `len`=0 means 2^WIDTH (256) cycles, because the terminal compare wraps.
- **Abort:** if `req[w]` is low in any RUN cycle, the next edge goes to IDLE with `gnt`=0 and no `done` pulse. `ptr` is updated to w.
- `req[w]` low during DONE is ignored; `done` still pulses.
- `len` changing during RUN has no effect.
- Requests from non-owners are ignored until IDLE; they are never lost, because they are levels.
- If the owner keeps `req` high after `done`, it is re-eligible, but round-robin gives the others precedence.
- **Reset:**
  - All outputs go to 0: `gnt`, `done`, `busy`, `owner`, `count`.
  - state=IDLE, `ptr`=NREQ-1, so requester 0 wins first.
  - Assertion mid-RUN or mid-DONE aborts immediately with no `done` pulse.

## Timing
- Request to grant: `req` seen high in IDLE at edge E0 → `gnt` high from E0.
- Grant duration is `len_q`+1 cycles (RUN plus DONE). `done` is high in the last of these.
- Minimum one IDLE cycle between consecutive grants. Per-grant throughput is `len_q`+2 cycles.
- `count` reads 0 in the first RUN cycle and `len_q`-1 in the last.
- All outputs are registered. No combinational path from `req` or `len` to any output.

## Structure
- Package `interval_timer_pkg` holds:
  - the state enum: IDLE, RUN, DONE;
  - `WIDTH_DEFAULT`=8;
  - the round-robin pick function (request vector, pointer → index, valid).
- Sub-module `interval_counter` has `clk`, `reset`, sync `clr`, `en` and `count[WIDTH]`. It is a synthesizable replacement for the delay-annotated counter: clr has priority over en, and it has no intra-assignment delays.
- The arbiter drives `clr`/`en` and holds `ptr`, `len_q`, the owner and the FSM.

## Test plan
- Single request: `req`=0001, `len[0]`=5 → `gnt`=0001 for 6 cycles; `count` 0..4; `done`=0001 in the 6th cycle; then `busy`=0 for ≥1 cycle.
- Round-robin: `req`=1111 held, all `len`=2 → grant order 0,1,2,3,0. Each grant lasts 3 cycles, separated by one IDLE cycle.
- Wrap length: `len[2]`=0 → `count` 0..255 then `done[2]` after 257 grant cycles total. `len[1]`=1 → a 2-cycle grant with `count`=0 only.
- Abort: `len[1]`=10; drop `req[1]` at `count`=3 → `gnt`=0 next edge with no `done`. With `req[2]` pending, requester 2 is granted after one IDLE cycle.
- Reset mid-RUN: assert `reset` at `count`=4 → all outputs 0 immediately. After release with `req`=1010, requester 1 is granted first.
- Length sampling: change `len[0]` from 5 to 9 two cycles into RUN → `done` still arrives after 5 RUN cycles.
